// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the KGP-RISC instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifetch_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 2;

  // Starved-decoder counter width and its saturation value
  localparam int                  STALL_W   = 16;
  localparam logic [STALL_W-1:0]  STALL_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Generic DEPTH x W register FIFO with synchronous clear and an occupancy count.
// Latency: pushed word is visible at the head the cycle after the push edge.
// Backpressure: caller must not push when full; pop while empty is ignored.
module ifetch_fifo #(
  parameter int W     = 42,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  input  logic                     clear,
  output logic [W-1:0]             head_dat,
  output logic                     head_vld,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_pop;

  assign do_pop   = pop && (count_q != '0);
  assign head_vld = (count_q != '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Storage, pointers and count; clear wins over any same-cycle pop or push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues one imem request at a time from the current PC, buffers words for decode.
// Latency: request one edge after room is seen; word at FIFO head the cycle after imem_ack.
// Backpressure: instr_ready stalls the FIFO; no request issues while it is full. Optional IFETCH_STALL_CNT_EN adds fetch_stall_cnt.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_advance,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              flush
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0] fetch_stall_cnt
`endif
);

  localparam int               CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_ent_t;

  ifetch_state_e     state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  fifo_cnt;
  fetch_ent_t        push_ent, head_ent;

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign pop       = instr_valid && instr_ready;
  assign push_ent  = '{instr: imem_rdata, pc: addr_q};
  assign instr     = head_ent.instr;
  assign instr_pc  = head_ent.pc;

  // Request/state registers; reset abandons any outstanding transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state: issue on room, accept or discard the ack, hold request through a dropped response
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    push       = 1'b0;
    pc_advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush && (fifo_cnt < DEPTH_CNT)) begin
          addr_d  = pc;
          req_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
          if (!flush) begin
            push       = 1'b1;
            pc_advance = 1'b1;
          end
        end else if (flush) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  ifetch_fifo #(
    .W     ($bits(fetch_ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .clear    (flush),
    .head_dat (head_ent),
    .head_vld (instr_valid),
    .count    (fifo_cnt)
  );

`ifdef IFETCH_STALL_CNT_EN
  logic [STALL_W-1:0] stall_cnt_q;
  assign fetch_stall_cnt = stall_cnt_q;

  // Count cycles the decoder wanted an instruction but none was buffered; saturates, flush-immune
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (instr_ready && !instr_valid && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch with a PC-register and memory model.
// Latency: n/a (testbench).
// Backpressure: randomizes instr_ready, memory latency and redirects.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pc_reg;
  logic        pc_advance;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_ready;
  logic        flush;
`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc_reg),
    .pc_advance  (pc_advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .flush       (flush)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .fetch_stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] dat;
  } exp_t;

  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  logic [9:0]  pop_log[$];
  int          pop_cnt, pa_cnt, fired;
  logic [9:0]  exp_pc;
  // stimulus knobs
  int          lat_lo, lat_hi;
  bit          ready_knob, rand_ready, rand_flush, stop_mem;
  bit          flush_req, flush_first_wait, flush_on_ack;
  logic [9:0]  flush_tgt;
  // memory model state
  bit          busy, tainted;
  int          wcnt, cur_lat;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return (32'h9E37_79B9 * ({22'd0, a} + 32'd1)) ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // One clock cycle: drive inputs at edge+1, check pc_advance at negedge, update models at edge
  task automatic step();
    bit ack_now, fl, acc, pa, f_wait, f_ack, f_rand;
    ack_now = 1'b0;
    if (imem_req) begin
      if (!busy) begin
        busy = 1'b1; wcnt = 0; tainted = 1'b0;
        cur_lat = $urandom_range(lat_hi, lat_lo);
      end
      ack_now = !stop_mem && (wcnt >= cur_lat);
    end
    imem_ack   = ack_now;
    imem_rdata = ack_now ? mem_word(imem_addr) : $urandom();
    f_wait = flush_first_wait && busy && (wcnt == 0);
    f_ack  = flush_on_ack && ack_now && (exp_q.size() >= 1);
    f_rand = rand_flush && ($urandom_range(15, 0) == 0);
    if (f_rand) flush_tgt = 10'($urandom_range(1023, 0));
    fl = flush_req || f_wait || f_ack || f_rand;
    flush_req = 1'b0;
    if (f_wait) flush_first_wait = 1'b0;
    if (f_ack) begin flush_on_ack = 1'b0; fired++; end
    flush       = fl;
    instr_ready = f_ack ? 1'b1 : (rand_ready ? 1'($urandom_range(1, 0)) : ready_knob);
    acc = ack_now && !fl && !tainted;
    @(negedge clk);
    chk("pc_advance", {31'd0, pc_advance}, {31'd0, acc});
    if (acc) chk("imem_addr", {22'd0, imem_addr}, {22'd0, exp_pc});
    pa = pc_advance;
    if (pa) pa_cnt++;
    @(posedge clk);
    if (fl && busy) tainted = 1'b1;
    if (acc) begin
      exp_q.push_back('{pc: exp_pc, dat: mem_word(exp_pc)});
      exp_pc = exp_pc + 10'd1;
    end
    if (fl) begin exp_q.delete(); exp_pc = flush_tgt; end
    if (ack_now) busy = 1'b0; else if (busy) wcnt++;
    #1;
    if (fl) pc_reg = flush_tgt;
    else if (pa) pc_reg = pc_reg + 10'd1;
  endtask

  task automatic do_reset(input logic [9:0] pcv);
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; flush = 1'b0;
    instr_ready = ready_knob;
    exp_q.delete(); pop_log.delete();
    busy = 1'b0; tainted = 1'b0; pop_cnt = 0; pa_cnt = 0;
    pc_reg = pcv;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    exp_pc = pc_reg;
  endtask

  // Monitor: every accepted head must match the next expected instruction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && instr_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL spurious_instr: got pc %0h, expected no instruction", instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", {22'd0, instr_pc}, {22'd0, e.pc});
          chk("instr", instr, e.dat);
        end
        pop_cnt++;
        pop_log.push_back(instr_pc);
      end
    end
  end

  initial begin
    bit found;
    lat_lo = 0; lat_hi = 0; ready_knob = 1'b1; rand_ready = 1'b0; rand_flush = 1'b0;
    stop_mem = 1'b0; flush_req = 1'b0; flush_first_wait = 1'b0; flush_on_ack = 1'b0;
    flush_tgt = '0; fired = 0;
    rst_n = 1'b0; pc_reg = '0; imem_ack = 1'b0; imem_rdata = '0; flush = 1'b0; instr_ready = 1'b0;
    #3;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", {22'd0, imem_addr}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", {22'd0, instr_pc}, 32'd0);

    // Zero-wait memory from pc 25: one instruction every two cycles
    do_reset(10'd25);
    repeat (40) step();
    chk("zw_pops", pop_cnt, 32'd19);
    chk("zw_advances", pa_cnt, 32'd20);

    // Decoder stalled: exactly two buffered, no further request, then in-order drain
    ready_knob = 1'b0;
    do_reset(10'd0);
    repeat (12) step();
    chk("full_advances", pa_cnt, 32'd2);
    chk("full_imem_req", {31'd0, imem_req}, 32'd0);
    chk("full_pc", {22'd0, pc_reg}, 32'd2);
    chk("full_valid", {31'd0, instr_valid}, 32'd1);
    ready_knob = 1'b1;
    repeat (20) step();
    chk("drain_first_pc", {22'd0, pop_log[0]}, 32'd0);

    // Redirect in the first wait cycle of a slow request
    lat_lo = 2; lat_hi = 2;
    do_reset(10'd5);
    flush_first_wait = 1'b1; flush_tgt = 10'd32;
    repeat (30) step();
    chk("redirect_pops", {31'd0, pop_log.size() > 0}, 32'd1);
    if (pop_log.size() > 0) chk("redirect_first_pc", {22'd0, pop_log[0]}, 32'd32);

    // Flush with a pop on a full FIFO, then flush coincident with ack and pop
    lat_lo = 0; lat_hi = 0; ready_knob = 1'b0;
    do_reset(10'd100);
    repeat (12) step();
    ready_knob = 1'b1; flush_req = 1'b1; flush_tgt = 10'd200;
    step();
    chk("flush_full_valid", {31'd0, instr_valid}, 32'd0);
    ready_knob = 1'b0; lat_lo = 3; lat_hi = 3; flush_on_ack = 1'b1; flush_tgt = 10'd300;
    for (int i = 0; i < 40 && fired == 0; i++) step();
    chk("flush_ack_fired", fired, 32'd1);
    chk("flush_ack_valid", {31'd0, instr_valid}, 32'd0);
    ready_knob = 1'b1;
    repeat (25) step();

    // Asynchronous reset while waiting with one entry buffered
    ready_knob = 1'b0; lat_lo = 5; lat_hi = 5;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      found = (exp_q.size() == 1) && busy;
    end
    chk("arst_setup", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("arst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_imem_addr", {22'd0, imem_addr}, 32'd0);
    imem_ack = 1'b0; flush = 1'b0;
    exp_q.delete(); busy = 1'b0; tainted = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; exp_pc = pc_reg;
    ready_knob = 1'b1; lat_lo = 0; lat_hi = 1;
    repeat (20) step();

    // Randomized traffic: variable ready, latency and redirects
    rand_ready = 1'b1; rand_flush = 1'b1; lat_lo = 0; lat_hi = 3;
    repeat (1500) step();
    rand_ready = 1'b0; rand_flush = 1'b0; ready_knob = 1'b1; stop_mem = 1'b1;
    repeat (10) step();
    chk("final_drain", exp_q.size(), 32'd0);
    chk("final_valid", {31'd0, instr_valid}, 32'd0);

`ifdef IFETCH_STALL_CNT_EN
    // Starved decoder: memory never answers, flush must not clear the counter
    do_reset(10'd7);
    chk("stall_rst", {16'd0, stall_cnt}, 32'd0);
    repeat (4) step();
    flush_req = 1'b1; flush_tgt = 10'd9;
    repeat (6) step();
    chk("stall_10", {16'd0, stall_cnt}, 32'd10);
    repeat (70000) step();
    chk("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the KGP-RISC core, directly downstream of the program counter register. Samples the current 10-bit PC, runs a request/acknowledge transaction to instruction memory, buffers returned words in a small FIFO toward the decoder, and pulses `pc_advance` so the next-PC logic loads PC+1. Handles pipeline flush on branch/jump redirect, including discard of an in-flight memory response.

## Interface
Parameters:
- `ADDR_W`, 10: PC / instruction-memory word-address width.
- `DATA_W`, 32: instruction width.
- `DEPTH`, 2: FIFO entries (power of two, ≥2).

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pc` input ADDR_W: current PC from the PC register.
- `pc_advance` output 1: combinational pulse; PC register loads PC+1 on this edge.
- `imem_req` output 1: registered memory request.
- `imem_addr` output ADDR_W: registered request address.
- `imem_ack` input 1: memory acknowledge; `imem_rdata` valid in same cycle.
- `imem_rdata` input DATA_W: fetched instruction.
- `instr_valid` output 1: FIFO head valid.
- `instr` output DATA_W: FIFO head instruction.
- `instr_pc` output ADDR_W: address of FIFO head instruction.
- `instr_ready` input 1: decoder accepts head this cycle.
- `flush` input 1: redirect; drop all buffered and in-flight instructions.
- `fetch_stall_cnt` output 16: only with `IFETCH_STALL_CNT_EN`.

## Operation
- FSM states: `S_IDLE`, `S_WAIT`, `S_DROP`.
- `S_IDLE`: if `!flush` and (count < DEPTH), at edge latch `imem_addr <= pc`, `imem_req <= 1`, go `S_WAIT`; else stay, `imem_req` 0.
- `S_WAIT`: `imem_req`/`imem_addr` held stable until `imem_ack`. On `imem_ack && !flush`: push {`imem_rdata`, `imem_addr`}, `pc_advance`=1, `imem_req <= 0`, go `S_IDLE`. On `imem_ack && flush`: discard, no `pc_advance`, go `S_IDLE`. On `flush && !imem_ack`: go `S_DROP`.
- `S_DROP`: request kept asserted, address stable; on `imem_ack` discard data, `imem_req <= 0`, go `S_IDLE`. Further `flush` ignored (stay `S_DROP`). `pc_advance` never asserted.
- `pc_advance` = (state==`S_WAIT`) && `imem_ack` && `!flush`; exactly one pulse per accepted instruction.
- FIFO: pop when `instr_valid && instr_ready`. Simultaneous push and pop allowed in any count. Issue gating guarantees push never occurs when full (at most one outstanding request; issue only if count < DEPTH).
- `flush` clears FIFO at the edge; pop in that cycle has no effect.
- Reset values: state `S_IDLE`, FIFO empty, `imem_req` 0, `imem_addr` 0, `instr_valid` 0, `instr` 0, `instr_pc` 0, `fetch_stall_cnt` 0. Reset asserted mid-transaction abandons it; memory must tolerate `imem_req` dropping.

## Timing
- Request issue: one edge after `S_IDLE` sees room; `imem_req` high from next cycle.
- Zero-wait memory (ack in first `imem_req` cycle): one instruction per 2 cycles; `instr_valid` high the cycle after ack.
- PC loads PC+1 on ack edge; `S_IDLE` samples the new PC the following cycle — never a stale PC.
- After flush, first request issues no earlier than one edge after the flush cycle (redirected PC already loaded).
- FIFO outputs driven from registers; no combinational path `imem_rdata`→`instr`.

## Configuration
- `IFETCH_STALL_CNT_EN` defined: 16-bit `fetch_stall_cnt` increments each cycle with `instr_ready && !instr_valid`, saturates at 16'hFFFF, cleared only by reset (not by flush).
- Undefined: counter logic and `fetch_stall_cnt` port absent; all other behaviour identical.

## Structure
- Package `ifetch_pkg`: FSM state enum, default `ADDR_W`/`DATA_W`/`DEPTH` constants, stall-counter width and saturation constant.
- One sub-module: `ifetch_fifo` (parameterised DEPTH×(DATA_W+ADDR_W) synchronous FIFO with push, pop, clear, count). FSM and counter live in `instr_fetch`.

## Test plan
- Reset then zero-wait memory, `pc`=25 from PC model, `instr_ready`=1 -> `imem_addr`=25, single `pc_advance`, `instr_pc`=25 then 26, 27 every 2 cycles.
- `instr_ready`=0, zero-wait memory -> exactly 2 entries (pcs 0,1), `imem_req` stays 0 afterwards; releasing ready drains in order and fetching resumes at pc 2.
- 3-cycle ack latency, `flush` asserted in first wait cycle with redirect to pc 32 -> data for old address discarded, no `pc_advance`, next `imem_addr`=32, first `instr_pc`=32.
- `flush` coincident with `imem_ack` and with a pop on a full FIFO -> FIFO empty next cycle, `instr_valid`=0, no `pc_advance`.
- `rst_n` pulled low while `S_WAIT` with 1 entry buffered -> `imem_req`, `instr_valid`, `imem_addr` all 0 immediately (asynchronous), fetch restarts from current `pc` after release.
- With `IFETCH_STALL_CNT_EN`: hold memory ack low 10 cycles with `instr_ready`=1 -> `fetch_stall_cnt` advances by the starved-cycle count; force 70000 starved cycles -> holds 16'hFFFF.
